// File: rtl/maxpool_relu_2_pkg.sv
// Shared dimensions and the per-pixel phase type for the second-layer max-pool + ReLU.
package maxpool_relu_2_pkg;

    localparam int CONV2_BIT   = 12;
    localparam int CONV2_OUT_W = 8;
    localparam int CONV2_OUT_H = 8;
    localparam int POOL2_OUT_W = CONV2_OUT_W / 2;
    localparam int POOL2_OUT_H = CONV2_OUT_H / 2;

    // What a channel does with the pixel presented this cycle.
    typedef enum logic [1:0] {
        PH_IDLE,
        PH_HOLD,
        PH_PAIR,
        PH_WINDOW
    } phase_e;

endpackage

// File: rtl/maxpool_relu_ch.sv
// One channel of the 2x2/stride-2 max-pool: pair register, half-width line buffer,
// signed max and ReLU on the output register.
module maxpool_relu_ch
    import maxpool_relu_2_pkg::*;
#(
    parameter int DATA_BIT = CONV2_BIT,
    parameter int DEPTH    = POOL2_OUT_W,
    parameter int IDX_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  phase_e              phase_i,
    input  logic [IDX_W-1:0]    idx_i,
    input  logic [DATA_BIT-1:0] pixel_i,
    output logic [DATA_BIT-1:0] max_value_o
);

    typedef logic signed [DATA_BIT-1:0] sample_t;

    function automatic sample_t smax(input sample_t a, input sample_t b);
        return (a > b) ? a : b;
    endfunction

    sample_t             hold_q, hold_d;
    sample_t             line_q [DEPTH];
    sample_t             pixel, pairMax, winMax;
    logic [DATA_BIT-1:0] max_q, max_d;
    logic                lineWe;

    assign pixel = $signed(pixel_i);

    always_comb begin
        hold_d  = hold_q;
        max_d   = max_q;
        lineWe  = 1'b0;
        pairMax = smax(hold_q, pixel);
        winMax  = smax(line_q[idx_i], pairMax);
        case (phase_i)
            PH_HOLD:   hold_d = pixel;
            PH_PAIR:   lineWe = 1'b1;
            // ReLU after the max: a negative window maximum clamps to zero
            PH_WINDOW: max_d  = winMax[DATA_BIT-1] ? '0 : winMax;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            max_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            hold_q <= hold_d;
            max_q  <= max_d;
            if (lineWe) begin
                line_q[idx_i] <= pairMax;
            end
        end
    end

    assign max_value_o = max_q;

endmodule

// File: rtl/maxpool_relu_2.sv
// Second-layer 2x2/stride-2 max-pool + ReLU over three lockstep conv2 channels.
// Shared raster counters drive the phase decode; each channel keeps its own pooling state.
module maxpool_relu_2
    import maxpool_relu_2_pkg::*;
#(
    parameter int DATA_BIT = CONV2_BIT,
    parameter int WIDTH    = CONV2_OUT_W,
    parameter int HEIGHT   = CONV2_OUT_H
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic [DATA_BIT-1:0] conv_out_1,
    input  logic [DATA_BIT-1:0] conv_out_2,
    input  logic [DATA_BIT-1:0] conv_out_3,
    output logic [DATA_BIT-1:0] max_value_1,
    output logic [DATA_BIT-1:0] max_value_2,
    output logic [DATA_BIT-1:0] max_value_3,
    output logic                valid_out
);

    localparam int COL_W = (WIDTH  > 2) ? $clog2(WIDTH)     : 1;
    localparam int ROW_W = (HEIGHT > 2) ? $clog2(HEIGHT)    : 1;
    localparam int IDX_W = (WIDTH  > 2) ? $clog2(WIDTH / 2) : 1;

    if (((WIDTH % 2) != 0) || ((HEIGHT % 2) != 0)) begin : g_bad_dims
        $error("maxpool_relu_2: WIDTH and HEIGHT must both be even");
    end

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             valid_q, valid_d;
    logic             is_even_col, is_even_row, fire;
    logic [IDX_W-1:0] idx;
    phase_e           phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
        end
    end

    // Counters only move on valid pixels, so idle gaps leave the raster position untouched
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (valid_in) begin
            if (col_q == COL_W'(WIDTH - 1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(HEIGHT - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_comb begin
        is_even_col = ~col_q[0];
        is_even_row = ~row_q[0];
        fire        = valid_in & ~is_even_col & ~is_even_row;
        valid_d     = fire;
        idx         = IDX_W'(col_q >> 1);
        phase       = PH_IDLE;
        if (valid_in) begin
            if (is_even_col) begin
                phase = PH_HOLD;
            end else if (is_even_row) begin
                phase = PH_PAIR;
            end else begin
                phase = PH_WINDOW;
            end
        end
    end

    maxpool_relu_ch #(.DATA_BIT(DATA_BIT), .DEPTH(WIDTH / 2), .IDX_W(IDX_W)) u_ch1 (
        .clk(clk), .rst(rst), .phase_i(phase), .idx_i(idx),
        .pixel_i(conv_out_1), .max_value_o(max_value_1)
    );

    maxpool_relu_ch #(.DATA_BIT(DATA_BIT), .DEPTH(WIDTH / 2), .IDX_W(IDX_W)) u_ch2 (
        .clk(clk), .rst(rst), .phase_i(phase), .idx_i(idx),
        .pixel_i(conv_out_2), .max_value_o(max_value_2)
    );

    maxpool_relu_ch #(.DATA_BIT(DATA_BIT), .DEPTH(WIDTH / 2), .IDX_W(IDX_W)) u_ch3 (
        .clk(clk), .rst(rst), .phase_i(phase), .idx_i(idx),
        .pixel_i(conv_out_3), .max_value_o(max_value_3)
    );

    assign valid_out = valid_q;

endmodule

// File: tb/tb_maxpool_relu_2.sv
// Self-checking bench for maxpool_relu_2: directed and random frames against a
// whole-frame reference that pools the received image window by window.
module tb_maxpool_relu_2;
    import maxpool_relu_2_pkg::*;

    localparam int DW   = CONV2_BIT;
    localparam int W    = CONV2_OUT_W;
    localparam int H    = CONV2_OUT_H;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst;
    logic          validIn;
    logic [DW-1:0] convOut1, convOut2, convOut3;
    logic [DW-1:0] maxValue1, maxValue2, maxValue3;
    logic          validOut;

    int checks = 0;
    int errors = 0;
    int pixIdx = 0;
    int strobes = 0;
    int strobesBefore;

    logic signed [DW-1:0] img [3][NPIX];
    logic signed [DW-1:0] frm [3][NPIX];
    logic        [DW-1:0] lastOut [3];

    maxpool_relu_2 dut (
        .clk(clk), .rst(rst), .valid_in(validIn),
        .conv_out_1(convOut1), .conv_out_2(convOut2), .conv_out_3(convOut3),
        .max_value_1(maxValue1), .max_value_2(maxValue2), .max_value_3(maxValue3),
        .valid_out(validOut)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pool the 2x2 window whose bottom-right pixel is (r,c), then rectify
    function automatic logic [DW-1:0] refPool(input int ch, input int r, input int c);
        logic signed [DW-1:0] m;
        logic signed [DW-1:0] v;
        m = img[ch][r * W + c];
        for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
                v = img[ch][(r - dr) * W + (c - dc)];
                if (v > m) m = v;
            end
        end
        return (m < 0) ? '0 : m;
    endfunction

    task automatic checkHold(input string tag);
        checkOutput({tag, "_valid"}, 32'(validOut), 32'd0);
        checkOutput({tag, "_ch1"}, 32'(maxValue1), 32'(lastOut[0]));
        checkOutput({tag, "_ch2"}, 32'(maxValue2), 32'(lastOut[1]));
        checkOutput({tag, "_ch3"}, 32'(maxValue3), 32'(lastOut[2]));
    endtask

    task automatic doReset();
        rst = 1'b1;
        validIn = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pixIdx = 0;
        for (int ch = 0; ch < 3; ch++) lastOut[ch] = '0;
        checkHold("reset");
    endtask

    task automatic idleCycle();
        validIn = 1'b0;
        @(posedge clk);
        #1;
        checkHold("idle");
    endtask

    task automatic sendPixel(input int p);
        int r, c;
        logic [DW-1:0] e0, e1, e2;
        r = pixIdx / W;
        c = pixIdx % W;
        for (int ch = 0; ch < 3; ch++) img[ch][pixIdx] = frm[ch][p];
        validIn  = 1'b1;
        convOut1 = frm[0][p];
        convOut2 = frm[1][p];
        convOut3 = frm[2][p];
        @(posedge clk);
        #1;
        validIn = 1'b0;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            e0 = refPool(0, r, c);
            e1 = refPool(1, r, c);
            e2 = refPool(2, r, c);
            checkOutput("strobe_valid", 32'(validOut), 32'd1);
            checkOutput("strobe_ch1", 32'(maxValue1), 32'(e0));
            checkOutput("strobe_ch2", 32'(maxValue2), 32'(e1));
            checkOutput("strobe_ch3", 32'(maxValue3), 32'(e2));
            lastOut[0] = e0;
            lastOut[1] = e1;
            lastOut[2] = e2;
            strobes++;
        end else begin
            checkHold("pixel");
        end
        pixIdx = (pixIdx + 1) % NPIX;
    endtask

    task automatic applyStimulus(input int count, input int gapMax);
        for (int p = 0; p < count; p++) begin
            if (gapMax > 0) repeat ($urandom_range(0, gapMax)) idleCycle();
            sendPixel(p);
        end
    endtask

    task automatic fillRamp();
        for (int p = 0; p < NPIX; p++) begin
            frm[0][p] = DW'(p);
            frm[1][p] = DW'(-p);
            frm[2][p] = DW'(100);
        end
    endtask

    task automatic fillRandom();
        for (int p = 0; p < NPIX; p++) begin
            for (int ch = 0; ch < 3; ch++) frm[ch][p] = DW'($urandom);
        end
    endtask

    initial begin
        rst = 1'b0;
        validIn = 1'b0;
        convOut1 = '0;
        convOut2 = '0;
        convOut3 = '0;

        // Long idle period straight after reset
        doReset();
        repeat (100) idleCycle();

        // Ramp frame: ch1 positive ramp, ch2 negated, ch3 constant
        fillRamp();
        strobesBefore = strobes;
        applyStimulus(NPIX, 0);
        checkOutput("ramp_strobes", 32'(strobes - strobesBefore), 32'd16);
        checkOutput("ramp_last_ch1", 32'(maxValue1), 32'd63);
        checkOutput("ramp_last_ch3", 32'(maxValue3), 32'd100);

        // Boundary windows in the top-left corner of each channel
        doReset();
        for (int p = 0; p < NPIX; p++) for (int ch = 0; ch < 3; ch++) frm[ch][p] = '0;
        frm[0][0] = -12'sd5;    frm[0][1] = 12'sd3;      frm[0][W] = -12'sd2048; frm[0][W+1] = 12'sd0;
        frm[1][0] = -12'sd1;    frm[1][1] = -12'sd1;     frm[1][W] = -12'sd1;    frm[1][W+1] = -12'sd1;
        frm[2][0] = 12'sd2047;  frm[2][1] = -12'sd2048;  frm[2][W] = 12'sd0;     frm[2][W+1] = 12'sd0;
        applyStimulus(W + 2, 0);
        checkOutput("win_mixed", 32'(maxValue1), 32'd3);
        checkOutput("win_neg", 32'(maxValue2), 32'd0);
        checkOutput("win_extreme", 32'(maxValue3), 32'd2047);
        applyStimulus(0, 0);
        for (int p = W + 2; p < NPIX; p++) sendPixel(p);

        // Ramp frame again with random idle gaps
        fillRamp();
        strobesBefore = strobes;
        applyStimulus(NPIX, 5);
        checkOutput("gap_strobes", 32'(strobes - strobesBefore), 32'd16);

        // Reset mid-frame, then a fresh ramp frame
        for (int p = 0; p < NPIX; p++) for (int ch = 0; ch < 3; ch++) frm[ch][p] = 12'sd2000;
        applyStimulus(20, 0);
        doReset();
        fillRamp();
        strobesBefore = strobes;
        applyStimulus(NPIX, 0);
        checkOutput("midreset_strobes", 32'(strobes - strobesBefore), 32'd16);

        // Two random frames back-to-back, no idle cycles
        strobesBefore = strobes;
        fillRandom();
        applyStimulus(NPIX, 0);
        fillRandom();
        applyStimulus(NPIX, 0);
        checkOutput("b2b_strobes", 32'(strobes - strobesBefore), 32'd32);

        // Random frames with random gaps
        for (int f = 0; f < 3; f++) begin
            fillRandom();
            applyStimulus(NPIX, 3);
        end
        idleCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: observed running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
